// File: rtl/qkd_status_pkg.sv
// Shared encodings for the QKD status/LED monitor: LED view modes and the
// network_fsm_TCP state values decoded for the TCP view.
package qkd_status_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_STICKY = 2'd1,
        MODE_TCP    = 2'd2,
        MODE_COUNT  = 2'd3
    } led_mode_t;

    typedef enum logic [3:0] {
        TCP_DISCONNECT = 4'd0,
        TCP_HANDSHAKE  = 4'd1,
        TCP_HANDSHAKE0 = 4'd2,
        TCP_TRANSFER   = 4'd3,
        TCP_HANDSHAKE1 = 4'd4,
        TCP_ACK_R      = 4'd5,
        TCP_ACK_T      = 4'd6
    } tcp_state_t;

    // States 0..TCP_NUM_LEGAL-1 get a one-hot LED; anything above is illegal.
    localparam int unsigned TCP_NUM_LEGAL = 7;

    // Event channels that have an LED in the LIVE and STICKY views.
    localparam int unsigned LED_EVT_CH = 6;

endpackage

// File: rtl/qkd_status_monitor_evt_latch_cnt.sv
// One event channel: rising-edge detect, sticky flag and saturating counter,
// with a clear that still keeps a rise arriving in the same cycle.
module evt_latch_cnt
    import qkd_status_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             clr,
    output logic             evt_q,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    logic rise;

    assign rise = evt & ~evt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            evt_q <= evt;
            if (clr && rise) begin
                sticky <= 1'b1;
                cnt    <= CNT_W'(1);
            end else if (clr) begin
                sticky <= 1'b0;
                cnt    <= '0;
            end else if (rise) begin
                sticky <= 1'b1;
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/qkd_status_monitor.sv
// Status/LED monitor for the Alice/Bob tops: per-channel event latches,
// heartbeat divider, TCP-state decode and a mode-selectable registered LED view.
module qkd_status_monitor
    import qkd_status_pkg::*;
#(
    parameter int unsigned NUM_EVT     = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned BLINK_DIV_W = 24,
    parameter int unsigned TCP_STATE_W = 4,
    localparam int unsigned SEL_W      = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_EVT-1:0]     evt_i,
    input  logic                   link_up_i,
    input  logic [TCP_STATE_W-1:0] tcp_state_i,
    input  logic [1:0]             mode_i,
    input  logic [SEL_W-1:0]       cnt_sel_i,
    input  logic                   clr_i,
    output logic [7:0]             led_o,
    output logic [NUM_EVT-1:0]     sticky_o,
    output logic [CNT_W-1:0]       cnt_o,
    output logic                   heartbeat_o,
    output logic                   clr_done_o
);

    localparam int unsigned LED_N = (NUM_EVT < LED_EVT_CH) ? NUM_EVT : LED_EVT_CH;
    localparam int unsigned CNT_LED_W = (CNT_W < 8) ? CNT_W : 8;

    logic [NUM_EVT-1:0]     evt_q;
    logic [NUM_EVT-1:0]     sticky;
    logic [CNT_W-1:0]       cnt [NUM_EVT];
    logic [BLINK_DIV_W-1:0] div;
    logic                   blink;
    logic                   tcp_est;
    logic                   tcp_legal;
    logic [6:0]             tcp_onehot;
    logic [LED_EVT_CH-1:0]  evt_q_led;
    logic [LED_EVT_CH-1:0]  sticky_led;
    logic [LED_EVT_CH-1:0]  sticky_view;
    logic [CNT_W-1:0]       cnt_sel_val;
    logic [7:0]             cnt_led;
    logic [7:0]             led_next;
    led_mode_t              mode;
    logic                   unused_hi_ch;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_ch
        evt_latch_cnt #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .evt   (evt_i[g]),
            .clr   (clr_i),
            .evt_q (evt_q[g]),
            .sticky(sticky[g]),
            .cnt   (cnt[g])
        );
    end

    assign sticky_o = sticky;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
        end else begin
            div <= div + BLINK_DIV_W'(1);
        end
    end

    assign blink       = div[BLINK_DIV_W-1];
    assign heartbeat_o = blink;

    // Channels above the LED range stay visible only through sticky_o/cnt_o.
    assign evt_q_led    = LED_EVT_CH'(evt_q[LED_N-1:0]);
    assign sticky_led   = LED_EVT_CH'(sticky[LED_N-1:0]);
    assign unused_hi_ch = ^{evt_q, sticky};

    // Done events glow solid; events still asserted blink with the heartbeat.
    assign sticky_view = sticky_led & ~(evt_q_led & {LED_EVT_CH{blink}});

    assign tcp_est    = (tcp_state_i == TCP_STATE_W'(TCP_TRANSFER));
    assign tcp_legal  = (32'(tcp_state_i) < TCP_NUM_LEGAL);
    assign tcp_onehot = 7'(1) << tcp_state_i;

    always_comb begin
        cnt_sel_val = '0;
        for (int unsigned i = 0; i < NUM_EVT; i++) begin
            if (32'(cnt_sel_i) == i) begin
                cnt_sel_val = cnt[i];
            end
        end
    end

    assign cnt_led = 8'(cnt_sel_val[CNT_LED_W-1:0]);
    assign mode    = led_mode_t'(mode_i);

    always_comb begin
        led_next = '0;
        case (mode)
            MODE_LIVE:   led_next = {link_up_i, tcp_est, evt_q_led};
            MODE_STICKY: led_next = {link_up_i, tcp_est, sticky_view};
            MODE_TCP: begin
                if (tcp_legal) begin
                    led_next = {link_up_i, tcp_onehot};
                end else begin
                    led_next = {link_up_i & blink, 7'b0};
                end
            end
            MODE_COUNT:  led_next = cnt_led;
            default:     led_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_o      <= '0;
            cnt_o      <= '0;
            clr_done_o <= 1'b0;
        end else begin
            led_o      <= led_next;
            cnt_o      <= cnt_sel_val;
            clr_done_o <= clr_i;
        end
    end

endmodule
